// File: rtl/microc_pkg.sv
// Shared definitions for the microc sequencing control unit: widths, opcode
// encodings/masks and the sequencer state encoding.
package microc_pkg;

  localparam int unsigned OPC_W = 6;
  localparam int unsigned OP_W  = 3;

  // ALU ops are 1xxxxx; li is 0001xx; the rest are exact codes.
  localparam logic [OPC_W-1:0] OPC_ALU      = 6'b100000;
  localparam logic [OPC_W-1:0] OPC_ALU_MASK = 6'b100000;
  localparam logic [OPC_W-1:0] OPC_NOP      = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_LI       = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_LI_MASK  = 6'b111100;
  localparam logic [OPC_W-1:0] OPC_J        = 6'b010000;
  localparam logic [OPC_W-1:0] OPC_JZ       = 6'b010001;
  localparam logic [OPC_W-1:0] OPC_JNZ      = 6'b010010;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StWaitStep,
    StHalt
  } state_e;

endpackage

// File: rtl/microc_decode.sv
// Combinational instruction decoder: opcode + zero flag -> datapath controls,
// plus a flag for undefined opcodes.
module microc_decode
  import microc_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [OP_W-1:0]  op,
  output logic             illegal
);

  // Decode the opcode classes; anything unmatched is flagged illegal.
  always_comb begin
    s_inc   = 1'b0;
    s_inm   = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    op      = '0;
    illegal = 1'b0;
    if ((opcode & OPC_ALU_MASK) == OPC_ALU) begin
      op    = opcode[4:2];
      s_inc = 1'b1;
      we3   = 1'b1;
      wez   = 1'b1;
    end else if ((opcode & OPC_LI_MASK) == OPC_LI) begin
      s_inc = 1'b1;
      s_inm = 1'b1;
      we3   = 1'b1;
    end else if (opcode == OPC_NOP) begin
      s_inc = 1'b1;
    end else if (opcode == OPC_J) begin
      s_inc = 1'b0;
    end else if (opcode == OPC_JZ) begin
      s_inc = ~z;
    end else if (opcode == OPC_JNZ) begin
      s_inc = z;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/microc_seq_ctrl.sv
// Multi-cycle sequencer for the microc datapath: fetch handshake, opcode
// latch, one-cycle execute, run/pause, single-step, illegal halt and a
// retired-instruction counter.
module microc_seq_ctrl
  import microc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_mode,
  input  logic             step,
  input  logic [OPC_W-1:0] opcode,
  input  logic             fetch_ack,
  input  logic             z,
  output logic             fetch_req,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic             we_pc,
  output logic [OP_W-1:0]  op,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  logic [OPC_W-1:0] dec_opc;
  logic             dec_s_inc, dec_s_inm, dec_we3, dec_wez, dec_illegal;
  logic [OP_W-1:0]  dec_op;
  logic             in_exec;

  assign in_exec = (state_q == StExec);

  // One decoder serves both phases: the live opcode while fetching (for the
  // legality check) and the latched opcode while executing.
  assign dec_opc = in_exec ? opc_q : opcode;

  microc_decode u_decode (
    .opcode  (dec_opc),
    .z       (z),
    .s_inc   (dec_s_inc),
    .s_inm   (dec_s_inm),
    .we3     (dec_we3),
    .wez     (dec_wez),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  // State, opcode latch, counter and sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      opc_q     <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic and fetch request.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    fetch_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        // run is ignored here so an outstanding request always completes.
        fetch_req = 1'b1;
        if (fetch_ack) begin
          opc_d = opcode;
          if (dec_illegal) begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        retired_d = retired_q + CNT_W'(1);
        if (!run)          state_d = StIdle;
        else if (step_mode) state_d = StWaitStep;
        else               state_d = StFetch;
      end
      StWaitStep: begin
        if (!run)                   state_d = StIdle;
        else if (step || !step_mode) state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath controls are live only during the execute cycle.
  always_comb begin
    s_inc = in_exec & dec_s_inc;
    s_inm = in_exec & dec_s_inm;
    we3   = in_exec & dec_we3;
    wez   = in_exec & dec_wez;
    we_pc = in_exec;
    op    = in_exec ? dec_op : '0;
  end

  assign busy    = (state_q == StFetch) || in_exec || (state_q == StWaitStep);
  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: doc/microc_seq_ctrl.md
Name: microc_seq_ctrl

Overview:
Multi-cycle sequencing control unit for the microc datapath. It fetches each 6-bit opcode over a req/ack handshake and latches it. It then drives the datapath controls for exactly one execute cycle: s_inc, s_inm, we3, wez, op, plus a PC write-enable. It also provides run/pause, single-step, illegal-opcode halt and a retired-instruction counter. It sits between the instruction memory handshake and the microc datapath.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  level; 1 = execute, 0 = pause at the next instruction boundary
step_mode  input  1  level; 1 = stop in WAIT_STEP after every instruction
step  input  1  single-cycle pulse; releases one instruction in step mode
opcode  input  6  instruction opcode from memory; valid while fetch_ack=1
fetch_ack  input  1  memory has opcode valid this cycle
z  input  1  datapath zero flag (registered in the datapath)
fetch_req  output  1  request next instruction
s_inc  output  1  PC source: 1 = PC+1, 0 = jump target
s_inm  output  1  register-file write source: 1 = immediate, 0 = ALU
we3  output  1  register-file write enable
wez  output  1  zero-flag write enable
we_pc  output  1  PC write enable
op  output  3  ALU operation
busy  output  1  state is FETCH, EXEC or WAIT_STEP
halted  output  1  state is HALT
illegal  output  1  sticky; last fetched opcode was undefined
retired  output  CNT_W  count of executed instructions

Behaviour:
- Reset (async, immediate):
  - state=IDLE; latched opcode=0; retired=0; illegal=0.
  - All outputs are 0 while reset=1, including any reset asserted mid-EXEC, so no write enable survives.
- States: IDLE, FETCH, EXEC, WAIT_STEP, HALT.
  - IDLE: all controls 0. If run=1, go to FETCH next cycle.
  - FETCH: fetch_req=1. On fetch_ack=1, latch opcode.
    - Defined opcode -> EXEC.
    - Undefined opcode -> HALT with illegal=1.
    - No ack -> stay in FETCH. run is ignored in FETCH, so an outstanding request always completes.
  - EXEC: exactly one cycle. we_pc=1 and the decoded controls are asserted; the datapath commits at the closing edge. retired increments, wrapping mod 2^CNT_W.
    - Next state: run=0 -> IDLE; else step_mode=1 -> WAIT_STEP; else FETCH.
  - WAIT_STEP: all controls 0. step=1 or step_mode=0 -> FETCH. run=0 has priority and goes to IDLE.
  - HALT: all controls 0, halted=1. Left only via reset.
- Outside EXEC: s_inc, s_inm, we3, wez, we_pc=0 and op=000.
- Decode, applied in EXEC from the latched opcode and the live z:
  - 1xxxxx (ALU): op=opcode[4:2]; s_inc=1; we3=1; wez=1; s_inm=0.
  - 000000 (nop): s_inc=1; all writes 0.
  - 0001xx (li): s_inc=1; s_inm=1; we3=1; wez=0; op=000.
  - 010000 (j): s_inc=0.
  - 010001 (jz): s_inc=~z.
  - 010010 (jnz): s_inc=z.
  - Jumps: we3=0, wez=0.
  - All other codes are undefined.
- z timing: the z sampled in a jump's EXEC is the value committed by the previous wez=1 EXEC. Back-to-back ALU-then-jz is therefore correct with no bubble.
- Minimum throughput: 2 cycles per instruction (FETCH with immediate ack, then EXEC).

Decomposition:
- Shared package microc_pkg holds:
  - opcode constants and masks: OPC_ALU, OPC_NOP, OPC_LI, OPC_J, OPC_JZ, OPC_JNZ;
  - state encoding;
  - OP_W=3 and OPC_W=6.
- One combinational sub-module, microc_decode: (opcode, z) -> s_inc, s_inm, we3, wez, op, illegal.
- The FSM, opcode latch and counter stay in microc_seq_ctrl.

Test Plan:
1. Reset, then run=1, fetch_ack always 1, opcodes 100100, 000101 -> each instruction takes 2 cycles. First EXEC: op=001, we3=1, wez=1, s_inc=1, we_pc=1. Second EXEC: s_inm=1, we3=1, wez=0. retired=2.
2. jz (010001) with z=1 -> s_inc=0, we_pc=1. Repeat with z=0 -> s_inc=1. jnz with the same two z values gives the inverse.
3. fetch_ack held 0 for 5 cycles with run dropped mid-wait -> fetch_req stays 1 and no we_pc pulse. On ack the instruction executes once, then the FSM returns to IDLE.
4. step_mode=1 -> after each EXEC the FSM sits in WAIT_STEP with busy=1 and we_pc=0. A 1-cycle step pulse executes exactly one more instruction; retired increments by 1.
5. Fetch opcode 001100 -> no EXEC and no write enables; halted=1 and illegal=1 persist with run=1 until reset clears both.
6. Reset asserted mid-EXEC (between clock edges) -> we_pc, we3 and wez drop to 0 immediately, and retired=0.
